// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types for the multi-channel PWM generator.
//   pwm_mode_e : counting mode of the shared period counter
//   dir_e      : count direction used by the center-aligned mode
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_period_ctr.sv
// pwm_period_ctr: shared period counter for pwm_multi.
// Holds the active period and mode, walks the counter in edge-aligned or
// center-aligned fashion, and flags the boundary tick where the next period
// starts. Period and mode requests are only taken at a boundary.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : count tick
//   period        : requested top count, sampled at a boundary
//   center        : requested mode (0 edge, 1 center), sampled at a boundary
//   counter       : current counter value
//   period_start  : registered one-clk pulse after each boundary tick
//   boundary      : combinational strobe, high on the boundary tick itself
module pwm_period_ctr
  import pwm_pkg::*;
#(
  parameter int                 WIDTH          = 8,
  parameter logic [WIDTH-1:0]   DEFAULT_PERIOD = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  logic             center,
  output logic [WIDTH-1:0] counter,
  output logic             period_start,
  output logic             boundary
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  dir_e             dir;
  dir_e             dir_nxt;
  pwm_mode_e        mode_act;
  logic [WIDTH-1:0] period_act;
  logic [WIDTH-1:0] counter_nxt;
  logic             wrap;

  // Next counter/direction and boundary detection for the active mode.
  always_comb begin
    counter_nxt = counter;
    dir_nxt     = dir;
    wrap        = 1'b0;
    if (period_act == ZERO) begin
      // Degenerate period: every tick restarts, direction never leaves up.
      counter_nxt = ZERO;
      dir_nxt     = DIR_UP;
      wrap        = 1'b1;
    end else begin
      case (mode_act)
        PWM_EDGE: begin
          if (counter == period_act) begin
            counter_nxt = ZERO;
            wrap        = 1'b1;
          end else begin
            counter_nxt = counter + ONE;
          end
        end
        PWM_CENTER: begin
          if ((dir == DIR_UP) && (counter != period_act)) begin
            counter_nxt = counter + ONE;
          end else begin
            // At the peak or on the way down. Landing on zero closes the
            // period; with period 1 the peak itself is that step.
            counter_nxt = counter - ONE;
            if (counter == ONE) begin
              dir_nxt = DIR_UP;
              wrap    = 1'b1;
            end else begin
              dir_nxt = DIR_DOWN;
            end
          end
        end
        default: begin
          counter_nxt = ZERO;
          dir_nxt     = DIR_UP;
          wrap        = 1'b1;
        end
      endcase
    end
  end

  assign boundary = enable & wrap;

  // Counter state, period/mode latching at boundaries, period_start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter      <= ZERO;
      dir          <= DIR_UP;
      period_act   <= DEFAULT_PERIOD;
      mode_act     <= PWM_EDGE;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (enable) begin
        counter <= counter_nxt;
        dir     <= dir_nxt;
        if (wrap) begin
          period_act <= period;
          mode_act   <= pwm_mode_e'(center);
        end
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: NCH-channel PWM generator sharing one period counter.
// Each channel has an active duty used by the compare and a shadow duty
// loaded through a valid/ready handshake; the shadow bank moves into the
// active bank only at a period boundary so pulses are never truncated.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : count tick
//   period        : requested top count (applied at a boundary)
//   center        : requested mode, 0 edge / 1 center (applied at a boundary)
//   duty_in       : packed duty set, channel i in [i*WIDTH +: WIDTH]
//   duty_valid    : duty_in carries a new set
//   duty_ready    : shadow bank free to accept
//   counter       : current period counter
//   period_start  : one-clk pulse after each boundary tick
//   pwm_out       : registered PWM outputs, one per channel
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int               NCH            = 2,
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = {WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     period,
  input  logic                 center,
  input  logic [NCH*WIDTH-1:0] duty_in,
  input  logic                 duty_valid,
  output logic                 duty_ready,
  output logic [WIDTH-1:0]     counter,
  output logic                 period_start,
  output logic [NCH-1:0]       pwm_out
);

  logic [WIDTH-1:0] active_duty [NCH];
  logic [WIDTH-1:0] shadow_duty [NCH];
  logic             pending;
  logic             accept;
  logic             boundary;
  logic [NCH-1:0]   cmp;

  pwm_period_ctr #(
    .WIDTH          (WIDTH),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_ctr (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .period       (period),
    .center       (center),
    .counter      (counter),
    .period_start (period_start),
    .boundary     (boundary)
  );

  assign duty_ready = ~pending;
  assign accept     = duty_valid & ~pending;

  // Shadow/active duty banks. Accept needs pending low, so a boundary that
  // consumes the shadow and a new accept never coincide; an accept on a
  // boundary tick with nothing pending waits for the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        active_duty[i] <= {WIDTH{1'b0}};
        shadow_duty[i] <= {WIDTH{1'b0}};
      end
    end else if (boundary && pending) begin
      pending <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        active_duty[i] <= shadow_duty[i];
      end
    end else if (accept) begin
      pending <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        shadow_duty[i] <= duty_in[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign cmp[i] = (counter < active_duty[i]);
  end

  // Compare result is registered every clk, independent of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= {NCH{1'b0}};
    end else begin
      pwm_out <= cmp;
    end
  end

endmodule
